// File: rtl/demultiplex_pkg.sv
// ---------------------------------------------------------------------------
// demultiplex_pkg
// Shared type definitions for the demultiplexer slice.
// Contents:
//   skid_state_e - occupancy of a two-entry skid stage, encoded as
//                  {skid_valid, output_valid}. The (1,0) code is unreachable.
// ---------------------------------------------------------------------------
package demultiplex_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/demultiplex_if.sv
// ---------------------------------------------------------------------------
// demultiplex_if
// Bundles the stream signals around the demultiplexer.
// Signals:
//   s_stb / s_dat / s_rdy : tagged input stream, s_dat = {tag, payload}
//   m_stb / m_dat / m_rdy : per-channel output streams; all m_dat lanes
//                           carry the same payload
//   err                   : sticky out-of-range-tag flag
// Modports:
//   slave  : the demultiplexer's view
//   master : the surrounding environment's view
// ---------------------------------------------------------------------------
interface demultiplex_if #(
    parameter int W = 8,
    parameter int N = 2
);
    localparam int T = $clog2(N);

    logic             s_stb;
    logic [T+W-1:0]   s_dat;
    logic             s_rdy;
    logic [N-1:0]     m_stb;
    logic [N*W-1:0]   m_dat;
    logic [N-1:0]     m_rdy;
    logic             err;

    modport slave (
        input  s_stb, s_dat, m_rdy,
        output s_rdy, m_stb, m_dat, err
    );

    modport master (
        output s_stb, s_dat, m_rdy,
        input  s_rdy, m_stb, m_dat, err
    );
endinterface

// File: rtl/demultiplex_skid_buffer.sv
// ---------------------------------------------------------------------------
// skid_buffer
// Two-entry registered stb/rdy stage. The output register feeds out_*;
// the skid register catches the one word that can arrive while the
// output is stalled, so in_rdy_o can be registered and still allow
// one word per cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_stb_i/in_dat_i   : upstream word
//   in_rdy_o            : upstream ready (registered)
//   out_stb_o/out_dat_o : downstream word (registered)
//   out_rdy_i           : downstream ready
// ---------------------------------------------------------------------------
module skid_buffer
    import demultiplex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_stb_i,
    input  logic [W-1:0] in_dat_i,
    output logic         in_rdy_o,
    output logic         out_stb_o,
    output logic [W-1:0] out_dat_o,
    input  logic         out_rdy_i
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         in_rdy_q, in_rdy_d;
    logic         ovld_s;
    logic         accept_s;
    logic         drain_s;

    assign ovld_s    = (state_q == ST_BUSY) || (state_q == ST_FULL);
    assign accept_s  = in_stb_i & in_rdy_q;
    assign drain_s   = ovld_s & out_rdy_i;
    assign in_rdy_o  = in_rdy_q;
    assign out_stb_o = ovld_s;
    assign out_dat_o = out_dat_q;

    // Next-state and data-path steering for the two storage entries
    always_comb begin
        state_d    = state_q;
        out_dat_d  = out_dat_q;
        skid_dat_d = skid_dat_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    out_dat_d = in_dat_i;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (accept_s && drain_s) begin
                    // Reload the output on the draining edge: no bubble.
                    out_dat_d  = in_dat_i;
                    state_d    = ST_BUSY;
                end else if (accept_s) begin
                    skid_dat_d = in_dat_i;
                    state_d    = ST_FULL;
                end else if (drain_s) begin
                    state_d    = ST_EMPTY;
                end else begin
                    state_d    = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    out_dat_d = skid_dat_q;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Ready is computed from the next state so it never depends on
        // out_rdy_i combinationally at the output.
        in_rdy_d = (state_d != ST_FULL);
    end

    // State, storage and ready registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_dat_q  <= '0;
            skid_dat_q <= '0;
            in_rdy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_dat_q  <= out_dat_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

endmodule

// File: rtl/demultiplex.sv
// ---------------------------------------------------------------------------
// demultiplex
// Tag-steered stream demultiplexer. Words {tag, payload} are buffered in a
// two-entry skid stage and presented on channel `tag`. Delivery is strictly
// in order: a stalled head word blocks every channel. Words whose tag is
// not below N are accepted, dropped, and set the sticky err flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : demultiplex_if.slave (s_stb/s_dat/s_rdy, m_stb/m_dat/m_rdy, err)
// ---------------------------------------------------------------------------
module demultiplex
    import demultiplex_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    demultiplex_if.slave   bus
);

    localparam int         T     = $clog2(N);
    localparam logic [T:0] N_LIM = (T+1)'(N);

    logic [T-1:0]   in_tag_s;
    logic           tag_ok_s;
    logic           skid_in_stb_s;
    logic           s_rdy_s;
    logic           ovld_s;
    logic [T+W-1:0] ohead_s;
    logic [T-1:0]   otag_s;
    logic           sel_rdy_s;
    logic [N-1:0]   m_stb_s;
    logic           err_q, err_d;

    assign in_tag_s      = bus.s_dat[T+W-1:W];
    assign tag_ok_s      = ({1'b0, in_tag_s} < N_LIM);
    // Bad-tag words never reach storage; they are swallowed by the handshake.
    assign skid_in_stb_s = bus.s_stb & tag_ok_s;
    assign otag_s        = ohead_s[T+W-1:W];

    skid_buffer #(
        .W (T+W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_stb_i  (skid_in_stb_s),
        .in_dat_i  (bus.s_dat),
        .in_rdy_o  (s_rdy_s),
        .out_stb_o (ovld_s),
        .out_dat_o (ohead_s),
        .out_rdy_i (sel_rdy_s)
    );

    // Tag decode: one-hot channel strobe and the selected channel's ready
    always_comb begin
        m_stb_s   = '0;
        sel_rdy_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (otag_s == T'(k)) begin
                m_stb_s[k] = ovld_s;
                sel_rdy_s  = bus.m_rdy[k];
            end else begin
                m_stb_s[k] = 1'b0;
            end
        end
    end

    // Sticky error next-state: set on accepting an out-of-range tag
    always_comb begin
        if (bus.s_stb && s_rdy_s && !tag_ok_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.s_rdy = s_rdy_s;
    assign bus.m_stb = m_stb_s;
    assign bus.m_dat = {N{ohead_s[W-1:0]}};
    assign bus.err   = err_q;

endmodule

// File: tb/tb_demultiplex.sv
// ---------------------------------------------------------------------------
// tb_demultiplex
// Directed vectors with hand-computed expectations for demultiplex
// (W=8, N=3), followed by a random phase checked against a FIFO model.
// ---------------------------------------------------------------------------
module tb_demultiplex;

    localparam int W = 8;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb_q[$];

    always #5 clk = ~clk;

    demultiplex_if #(.W(W), .N(N)) bus ();

    demultiplex #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] lanes(input logic [7:0] b);
        return {b, b, b};
    endfunction

    task automatic expect_out(input string tag, input logic [2:0] stb, input logic [7:0] dat);
        chk({tag, "_stb"}, 32'(bus.m_stb), 32'(stb));
        chk({tag, "_dat"}, 32'(bus.m_dat), 32'(lanes(dat)));
    endtask

    initial begin
        logic       acc;
        logic       drn;
        logic [1:0] dtag;
        logic [9:0] exp_w;

        rst       = 1'b1;
        bus.s_stb = 1'b0;
        bus.s_dat = '0;
        bus.m_rdy = 3'b000;
        tick();
        tick();
        chk("rst_stb",  32'(bus.m_stb), 32'd0);
        chk("rst_dat",  32'(bus.m_dat), 32'd0);
        chk("rst_rdy",  32'(bus.s_rdy), 32'd0);
        chk("rst_err",  32'(bus.err),   32'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy0", 32'(bus.s_rdy), 32'd0);
        tick();
        chk("rel_rdy1", 32'(bus.s_rdy), 32'd1);

        // Back-to-back words to three channels, all ready
        bus.m_rdy = 3'b111;
        bus.s_stb = 1'b1;
        bus.s_dat = {2'd0, 8'hAA};
        tick();
        expect_out("b2b_a", 3'b001, 8'hAA);
        chk("b2b_rdy_a", 32'(bus.s_rdy), 32'd1);
        bus.s_dat = {2'd1, 8'hBB};
        tick();
        expect_out("b2b_b", 3'b010, 8'hBB);
        chk("b2b_rdy_b", 32'(bus.s_rdy), 32'd1);
        bus.s_dat = {2'd2, 8'hCC};
        tick();
        expect_out("b2b_c", 3'b100, 8'hCC);
        chk("b2b_rdy_c", 32'(bus.s_rdy), 32'd1);
        bus.s_stb = 1'b0;
        tick();
        chk("b2b_idle", 32'(bus.m_stb), 32'd0);

        // Stall: fill both entries, then drain in order
        bus.m_rdy = 3'b000;
        bus.s_stb = 1'b1;
        bus.s_dat = {2'd1, 8'h11};
        tick();
        expect_out("stl_1", 3'b010, 8'h11);
        chk("stl_rdy1", 32'(bus.s_rdy), 32'd1);
        bus.s_dat = {2'd0, 8'h22};
        tick();
        expect_out("stl_2", 3'b010, 8'h11);
        chk("stl_rdy2", 32'(bus.s_rdy), 32'd0);
        bus.s_stb = 1'b0;
        bus.m_rdy = 3'b101;   // unselected readies must be ignored
        tick();
        expect_out("stl_hold", 3'b010, 8'h11);
        chk("stl_rdy3", 32'(bus.s_rdy), 32'd0);
        bus.m_rdy = 3'b010;
        tick();
        expect_out("stl_skid", 3'b001, 8'h22);
        chk("stl_rdy4", 32'(bus.s_rdy), 32'd1);
        bus.m_rdy = 3'b001;
        tick();
        chk("stl_empty", 32'(bus.m_stb), 32'd0);

        // Out-of-range tag between valid words
        bus.m_rdy = 3'b111;
        bus.s_stb = 1'b1;
        bus.s_dat = {2'd0, 8'h01};
        tick();
        expect_out("bad_pre", 3'b001, 8'h01);
        chk("bad_err0", 32'(bus.err), 32'd0);
        bus.s_dat = {2'd3, 8'h55};
        chk("bad_acc", 32'(bus.s_rdy), 32'd1);
        tick();
        chk("bad_nostb", 32'(bus.m_stb), 32'd0);
        chk("bad_err1", 32'(bus.err), 32'd1);
        bus.s_dat = {2'd2, 8'h66};
        tick();
        expect_out("bad_post", 3'b100, 8'h66);
        bus.s_stb = 1'b0;
        tick();
        chk("bad_idle", 32'(bus.m_stb), 32'd0);
        chk("bad_err2", 32'(bus.err), 32'd1);

        // Head-of-line: channel 2 stalled blocks a word for ready channel 0
        bus.m_rdy = 3'b000;
        bus.s_stb = 1'b1;
        bus.s_dat = {2'd2, 8'h01};
        tick();
        expect_out("hol_head", 3'b100, 8'h01);
        bus.m_rdy = 3'b001;
        bus.s_dat = {2'd0, 8'h02};
        tick();
        expect_out("hol_blk1", 3'b100, 8'h01);
        bus.s_stb = 1'b0;
        tick();
        expect_out("hol_blk2", 3'b100, 8'h01);
        bus.m_rdy = 3'b101;
        tick();
        expect_out("hol_next", 3'b001, 8'h02);
        tick();
        chk("hol_idle", 32'(bus.m_stb), 32'd0);

        // Asynchronous reset while FULL
        bus.m_rdy = 3'b000;
        bus.s_stb = 1'b1;
        bus.s_dat = {2'd0, 8'hAA};
        tick();
        bus.s_dat = {2'd1, 8'hBB};
        tick();
        bus.s_stb = 1'b0;
        chk("ar_full", 32'(bus.s_rdy), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_stb", 32'(bus.m_stb), 32'd0);
        chk("ar_dat", 32'(bus.m_dat), 32'd0);
        chk("ar_rdy", 32'(bus.s_rdy), 32'd0);
        chk("ar_err", 32'(bus.err),   32'd0);
        tick();
        rst = 1'b0;
        bus.m_rdy = 3'b111;
        tick();
        chk("ar_rdy1", 32'(bus.s_rdy), 32'd1);
        chk("ar_old", 32'(bus.m_stb), 32'd0);
        bus.s_stb = 1'b1;
        bus.s_dat = {2'd2, 8'h77};
        tick();
        expect_out("ar_new", 3'b100, 8'h77);
        bus.s_stb = 1'b0;
        tick();
        chk("ar_gone1", 32'(bus.m_stb), 32'd0);
        tick();
        chk("ar_gone2", 32'(bus.m_stb), 32'd0);

        // Random traffic against a FIFO model
        for (int c = 0; c < 3000; c++) begin
            bus.s_stb = 1'($urandom_range(0, 1));
            bus.s_dat = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            bus.m_rdy = 3'($urandom_range(0, 7));
            chk("rnd_onehot", 32'($onehot0(bus.m_stb)), 32'd1);
            acc  = bus.s_stb & bus.s_rdy;
            drn  = 1'b0;
            dtag = 2'd0;
            for (int k = 0; k < N; k++) begin
                if (bus.m_stb[k] && bus.m_rdy[k]) begin
                    drn  = 1'b1;
                    dtag = 2'(k);
                end
            end
            if (drn) begin
                if (sb_q.size() == 0) begin
                    chk("rnd_spurious", 32'({dtag, bus.m_dat[7:0]}), 32'h3ff);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("rnd_word", 32'({dtag, bus.m_dat[7:0]}), 32'(exp_w));
                    chk("rnd_lanes", 32'(bus.m_dat), 32'(lanes(exp_w[7:0])));
                end
            end
            if (acc && bus.s_dat[9:8] != 2'd3) begin
                sb_q.push_back(bus.s_dat);
            end
            tick();
        end

        // Drain whatever remains, bounded
        bus.s_stb = 1'b0;
        bus.m_rdy = 3'b111;
        for (int c = 0; c < 20; c++) begin
            if (bus.m_stb != 3'b000) begin
                dtag = 2'd0;
                for (int k = 0; k < N; k++) begin
                    if (bus.m_stb[k]) dtag = 2'(k);
                end
                if (sb_q.size() == 0) begin
                    chk("drn_spurious", 32'({dtag, bus.m_dat[7:0]}), 32'h3ff);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("drn_word", 32'({dtag, bus.m_dat[7:0]}), 32'(exp_w));
                end
            end
            tick();
        end
        chk("drn_left", 32'(sb_q.size()), 32'd0);
        chk("drn_idle", 32'(bus.m_stb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
